// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared definitions for the UART transmitter.
//   - DEF_* constants: default parameter values for uart_tx.
//   - uart_tx_state_t: transmitter FSM state encoding.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_DIV_WIDTH = 16;
  localparam int DEF_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen: bit-period timer for the UART transmitter.
// Counts 0..div while enabled and emits a one-cycle bit_done pulse on the
// last cycle of every period (every div+1 cycles). Disabling clears the count.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   en       : count enable (low clears the counter)
//   div      : clocks per bit minus 1
//   bit_done : high on the final cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_done
);

  logic [DIV_WIDTH-1:0] cnt;

  assign bit_done = en && (cnt == div);

  // Wrapping on bit_done restarts every period at 0, so nothing carries over
  // from one bit into the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx: UART serial transmitter (start bit, LSB-first payload, optional
// even parity, 1..2 stop bits).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the payload and the stop bits.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   div     : clocks per bit minus 1, captured when a frame is accepted
//   data_in : frame payload, captured when a frame is accepted
//   valid   : producer offers data_in
//   ready   : transmitter idle and able to accept a frame
//   tx      : serial line, idle high
//   busy    : a frame is in progress (!ready)
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t       state, state_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 bit_done;
  logic                 baud_en;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  assign ready   = (state == IDLE);
  assign busy    = !ready;
  assign accept  = valid && ready;
  assign baud_en = (state != IDLE);

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (baud_en),
    .div      (div_reg),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx is decoded from state so an asynchronous reset drives the line high
  // immediately, without waiting for a clock edge.
  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_done && (bit_idx == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par;
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_done && (stop_idx == LAST_STOP)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame payload and divisor are captured only on acceptance, so input
  // changes while busy cannot disturb the frame on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      div_reg  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (accept) begin
      shreg    <= data_in;
      div_reg  <= div;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= ^data_in;
`endif
    end else if (bit_done) begin
      if (state == DATA) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 4'd1;
      end
      if (state == STOP) begin
        stop_idx <= !stop_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx: scoreboard bench for uart_tx (DATA_BITS=8, STOP_BITS=1).
// Stimulus pushes each accepted frame into a queue; the monitor detects the
// start bit on tx, pops the expected frame and checks every cycle of every
// bit against the frame model.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic        clk;
  logic        reset;
  logic [15:0] div;
  logic [7:0]  data_in;
  logic        valid;
  logic        ready;
  logic        tx;
  logic        busy;

  typedef struct {
    logic [7:0] data;
    int         dv;
  } item_t;

  item_t exp_q[$];
  int    n_checks    = 0;
  int    n_fail      = 0;
  int    idle_cnt    = 0;
  int    last_gap    = -1;
  int    frames_done = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  uart_tx dut (
    .clk     (clk),
    .reset   (reset),
    .div     (div),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Line level of bit b of a frame: start, LSB-first data, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    item_t it;
    bit    aborted;
    bit    ok;
    logic  seen;
    logic  want;
    int    guard;
    forever begin
      @(negedge clk);
      if (!reset) begin
        idle_cnt = 0;
      end else if (tx) begin
        idle_cnt++;
      end else begin
        last_gap = idle_cnt;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", 1, 0);
          guard = 0;
          while (!tx && reset && guard < 1000) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          it = exp_q.pop_front();
          aborted = 1'b0;
          for (int b = 0; b < NBITS && !aborted; b++) begin
            ok   = 1'b1;
            want = exp_bit(it.data, b);
            seen = want;
            for (int c = 0; c <= it.dv; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!reset) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== want) begin
                ok   = 1'b0;
                seen = tx;
              end
            end
            if (!aborted)
              check(ok, $sformatf("frame_%02h_bit%0d", it.data, b), int'(seen), int'(want));
          end
          if (!aborted) frames_done++;
        end
        idle_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic [15:0] dv);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check(1'b0, "send_ready_timeout", 0, 1);
    data_in = d;
    div     = dv;
    valid   = 1'b1;
    exp_q.push_back('{data: d, dv: int'(dv)});
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge; counts edges until ready.
  task automatic wait_ready(input int req, input string name);
    int n = 0;
    while (!ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n == req, name, n, req);
  endtask

  initial begin : stim
    reset   = 1'b0;
    valid   = 1'b0;
    data_in = 8'h00;
    div     = 16'd0;
    repeat (3) @(negedge clk);
    check(tx == 1'b1,    "reset_tx",    int'(tx),    1);
    check(ready == 1'b1, "reset_ready", int'(ready), 1);
    check(busy == 1'b0,  "reset_busy",  int'(busy),  0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check(tx == 1'b1, "idle_tx", int'(tx), 1);

    // single frame, 4 cycles per bit
    send(8'hA5, 16'd3);
    check(busy == 1'b1 && ready == 1'b0, "busy_after_accept", int'(busy), 1);
    wait_ready(NBITS * 4, "a5_ready_latency");

    // minimum divisor: 9 low cycles then stop
    send(8'h00, 16'd0);
    wait_ready(NBITS, "div0_ready_latency");

    // back-to-back with valid held high
    send(8'h55, 16'd1);
    valid   = 1'b1;
    data_in = 8'hFF;
    exp_q.push_back('{data: 8'hFF, dv: 1});
    wait_ready(NBITS * 2, "b2b_first_latency");
    @(posedge clk);
    #1;
    valid = 1'b0;
    check(busy == 1'b1, "b2b_second_accepted", int'(busy), 1);
    wait_ready(NBITS * 2, "b2b_second_latency");
    check(last_gap == 1, "b2b_idle_gap", last_gap, 1);

    // mid-frame reset during data bit 3
    send(8'h0F, 16'd3);
    repeat (17) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check(tx == 1'b1,    "midreset_tx",    int'(tx),    1);
    check(ready == 1'b1, "midreset_ready", int'(ready), 1);
    check(busy == 1'b0,  "midreset_busy",  int'(busy),  0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check(ready == 1'b1 && tx == 1'b1, "after_reset_idle", int'(ready), 1);
    send(8'h81, 16'd3);
    wait_ready(NBITS * 4, "post_reset_latency");

    // inputs disturbed while busy
    send(8'h3C, 16'd2);
    repeat (8) @(posedge clk);
    #1;
    data_in = 8'hFF;
    div     = 16'd0;
    valid   = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check(busy == 1'b1, "ignored_busy", int'(busy), 1);
    wait_ready(NBITS * 3 - 9, "ignored_latency");
    repeat (20) @(negedge clk);
    check(tx == 1'b1 && ready == 1'b1, "no_extra_frame", int'(tx), 1);

    // parity values (odd and even payload weight)
    send(8'h07, 16'd2);
    wait_ready(NBITS * 3, "p07_latency");
    send(8'h03, 16'd2);
    wait_ready(NBITS * 3, "p03_latency");

    repeat (10) @(negedge clk);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    check(frames_done == 8, "frames_done", frames_done, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
